// File: rtl/siso_pkg.sv
// Shared constants and types for the SISO decoder datapath: supported LTE block
// lengths with their QPP coefficients, default widths and the buffer state encoding.
package siso_pkg;

    localparam int MAX_K_DEFAULT = 6144;
    localparam int AW_DEFAULT    = 13;
    localparam int DW_DEFAULT    = 16;

    localparam int K_40   = 40;
    localparam int F1_40  = 3;
    localparam int F2_40  = 10;
    localparam int K_512  = 512;
    localparam int F1_512 = 31;
    localparam int F2_512 = 64;
    localparam int K_6144 = 6144;
    localparam int F1_6144 = 263;
    localparam int F2_6144 = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } buf_state_t;

    typedef enum logic [1:0] {
        KSEL_40   = 2'd0,
        KSEL_512  = 2'd1,
        KSEL_6144 = 2'd2,
        KSEL_NONE = 2'd3
    } ksel_t;

    function automatic ksel_t decode_k(input logic [15:0] k);
        case (k)
            16'd40:   return KSEL_40;
            16'd512:  return KSEL_512;
            16'd6144: return KSEL_6144;
            default:  return KSEL_NONE;
        endcase
    endfunction

    function automatic int k_of(input ksel_t s);
        case (s)
            KSEL_40:   return K_40;
            KSEL_512:  return K_512;
            KSEL_6144: return K_6144;
            default:   return 1;
        endcase
    endfunction

    // Starting increment of the recursion: pi(1) - pi(0) = f1 + f2
    function automatic int g0_of(input ksel_t s);
        case (s)
            KSEL_40:   return (F1_40 + F2_40) % K_40;
            KSEL_512:  return (F1_512 + F2_512) % K_512;
            KSEL_6144: return (F1_6144 + F2_6144) % K_6144;
            default:   return 0;
        endcase
    endfunction

    // Second difference of the quadratic permutation is the constant 2*f2
    function automatic int d_of(input ksel_t s);
        case (s)
            KSEL_40:   return (2 * F2_40) % K_40;
            KSEL_512:  return (2 * F2_512) % K_512;
            KSEL_6144: return (2 * F2_6144) % K_6144;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Multiplier-free QPP interleaver address generator: pi(i) built incrementally
// from a first difference g and a constant second difference d.
module qpp_addr_gen
    import siso_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  ksel_t         k_sel,
    input  logic          advance,
    output logic [AW-1:0] pi
);

    ksel_t         sel_q;
    logic [AW-1:0] g;
    logic [AW-1:0] k_val;
    logic [AW-1:0] d_val;
    logic [AW:0]   k_ext;
    logic [AW:0]   pi_sum;
    logic [AW:0]   pi_sub;
    logic [AW:0]   g_sum;
    logic [AW:0]   g_sub;
    logic [AW-1:0] pi_next;
    logic [AW-1:0] g_next;

    assign k_val = AW'(k_of(sel_q));
    assign d_val = AW'(d_of(sel_q));
    assign k_ext = {1'b0, k_val};

    // Both operands are already reduced mod K, so one conditional subtract suffices
    always_comb begin
        pi_sum  = {1'b0, pi} + {1'b0, g};
        pi_sub  = pi_sum - k_ext;
        g_sum   = {1'b0, g} + {1'b0, d_val};
        g_sub   = g_sum - k_ext;
        pi_next = (pi_sum >= k_ext) ? pi_sub[AW-1:0] : pi_sum[AW-1:0];
        g_next  = (g_sum >= k_ext) ? g_sub[AW-1:0] : g_sum[AW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pi    <= '0;
            g     <= '0;
            sel_q <= KSEL_NONE;
        end else if (init) begin
            pi    <= '0;
            g     <= AW'(g0_of(k_sel));
            sel_q <= k_sel;
        end else if (advance) begin
            pi <= pi_next;
            g  <= g_next;
        end
    end

endmodule

// File: rtl/qpp_extrinsic_buffer.sv
// Captures one block of SISO extrinsic samples and replays it as the apriori stream
// for the next half-iteration, alternating natural and QPP-interleaved read order.
module qpp_extrinsic_buffer
    import siso_pkg::*;
#(
    parameter int MAX_K = MAX_K_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   blklen,
    input  logic          valid_blklen,
    input  logic          interleave,
    input  logic [DW-1:0] extrinsic,
    input  logic          valid_extrinsic,
    input  logic          apriori_req,
    output logic [DW-1:0] apriori,
    output logic          valid_apriori,
    output logic          last_apriori,
    output logic          ready,
    output logic          error_blklen,
    output logic          overflow
);

    buf_state_t    state, state_next;
    ksel_t         blk_sel;
    ksel_t         k_sel_q;
    ksel_t         gen_sel;
    logic          blk_ok;
    logic [AW-1:0] k_len;
    logic [AW-1:0] k_last;
    logic          ilv;
    logic [AW-1:0] wcnt;
    logic [AW-1:0] rcnt;
    logic [AW-1:0] pi;
    logic [AW-1:0] raddr;
    logic          wr_en, rd_en, last_wr, last_rd, gen_init;
    logic [DW-1:0] mem [MAX_K];

    assign blk_sel  = decode_k(blklen);
    assign blk_ok   = (blk_sel != KSEL_NONE);
    assign k_last   = k_len - AW'(1);
    // A new block length aborts everything in flight, so it masks both ports
    assign wr_en    = (state == WRITE) && valid_extrinsic && !valid_blklen;
    assign rd_en    = (state == READ) && apriori_req && !valid_blklen;
    assign last_wr  = wr_en && (wcnt == k_last);
    assign last_rd  = rd_en && (rcnt == k_last);
    assign gen_init = valid_blklen || last_wr || last_rd;
    assign gen_sel  = valid_blklen ? blk_sel : k_sel_q;
    assign raddr    = ilv ? pi : rcnt;
    assign ready    = (state == WRITE);

    qpp_addr_gen #(.AW(AW)) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .init    (gen_init),
        .k_sel   (gen_sel),
        .advance (rd_en),
        .pi      (pi)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (valid_blklen) begin
            state_next = blk_ok ? WRITE : IDLE;
        end else begin
            case (state)
                WRITE:   if (last_wr) state_next = READ;
                READ:    if (last_rd) state_next = WRITE;
                default: state_next = state;
            endcase
        end
    end

    // Finishing a read pass flips the order for the next half-iteration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_len   <= '0;
            k_sel_q <= KSEL_NONE;
            ilv     <= 1'b0;
            wcnt    <= '0;
            rcnt    <= '0;
        end else if (valid_blklen) begin
            k_len   <= blklen[AW-1:0];
            k_sel_q <= blk_sel;
            ilv     <= interleave;
            wcnt    <= '0;
            rcnt    <= '0;
        end else begin
            if (wr_en) wcnt <= last_wr ? '0 : wcnt + AW'(1);
            if (rd_en) begin
                rcnt <= last_rd ? '0 : rcnt + AW'(1);
                if (last_rd) ilv <= ~ilv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wcnt] <= extrinsic;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            apriori       <= '0;
            valid_apriori <= 1'b0;
            last_apriori  <= 1'b0;
            error_blklen  <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (rd_en) apriori <= mem[raddr];
            valid_apriori <= rd_en;
            last_apriori  <= last_rd;
            error_blklen  <= valid_blklen && !blk_ok;
            overflow      <= valid_extrinsic && !wr_en;
        end
    end

endmodule
